// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants and helpers for the multi-channel 7-segment debug display.
//   SEG_BLANK      : all segments off (active-low)
//   HEX_SEG        : 16-entry nibble -> active-low segment table, bit order g..a
//   hexToSeg       : table lookup for one nibble
//   keyAcceptWidth : counter width needed to count up to a debounce length
// No ports (package).
// -----------------------------------------------------------------------------
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, seg[6]=g ... seg[0]=a
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

  // Width of a counter that must reach cycles-1 (never narrower than 1 bit)
  function automatic int keyAcceptWidth(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Two-flop synchroniser for a raw pushbutton, followed by a stable-level
// filter and a one-cycle rising-edge pulse of the accepted level.
// Ports:
//   iwClk  in  1  clock
//   iwRst  in  1  synchronous active-high reset
//   iwKey  in  1  raw asynchronous key, active-high
//   owRise out 1  one-cycle pulse when the accepted level goes 0 -> 1
// -----------------------------------------------------------------------------
module key_debouncer
  import disp_pkg::*;
#(
  parameter int pDebounce = 1000000
) (
  input  logic iwClk,
  input  logic iwRst,
  input  logic iwKey,
  output logic owRise
);

  localparam int CNT_W = keyAcceptWidth(pDebounce);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rise_r;

  // Synchronise the key, count consecutive cycles away from the accepted level, accept after pDebounce
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= '0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= iwKey;
      sync2_r <= sync1_r;
      rise_r  <= 1'b0;
      // A return to the accepted level is the only possible change while counting, so it restarts the count
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_W'(pDebounce - 1)) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
        rise_r  <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign owRise = rise_r;

endmodule

// File: rtl/multi_channel_display_scanner.sv
// -----------------------------------------------------------------------------
// multi_channel_display_scanner
// Scans pDigits multiplexed 7-segment digits showing the low hex nibbles of
// one of pChannels 32-bit debug buses. A frame-start snapshot keeps each frame
// consistent; a debounced key toggles a freeze that suppresses reloading.
// Each digit slot begins with pGuard cycles of all anodes off.
// Optional feature macro: DISP_LEADING_ZERO_BLANK_EN -- blank digits above the
// most-significant nonzero nibble (digit 0 always shown).
// Ports:
//   iwClk    in  1               board clock
//   iwRst    in  1               synchronous active-high reset
//   iwData   in  32*pChannels    channel c at [32*c+31:32*c]
//   iwSel    in  SEL_W           channel select, out-of-range -> channel 0
//   iwKey    in  1               raw pushbutton, active-high
//   ownSeg   out 7               segments g..a, active-low
//   ownAn    out pDigits         anodes, active-low, at most one low
//   owFrozen out 1               display held
// -----------------------------------------------------------------------------
module multi_channel_display_scanner
  import disp_pkg::*;
#(
  parameter int pDigits     = 4,
  parameter int pChannels   = 4,
  parameter int pRefreshDiv = 100000,
  parameter int pGuard      = 4,
  parameter int pDebounce   = 1000000
) (
  input  logic                                           iwClk,
  input  logic                                           iwRst,
  input  logic [32*pChannels-1:0]                        iwData,
  input  logic [((pChannels > 1) ? $clog2(pChannels) : 1)-1:0] iwSel,
  input  logic                                           iwKey,
  output logic [6:0]                                     ownSeg,
  output logic [pDigits-1:0]                             ownAn,
  output logic                                           owFrozen
);

  localparam int SEL_W  = (pChannels > 1) ? $clog2(pChannels) : 1;
  localparam int DIG_W  = (pDigits > 1) ? $clog2(pDigits) : 1;
  localparam int SLOT_W = $clog2(pRefreshDiv);
  localparam logic [pDigits-1:0] AN_OFF = {pDigits{1'b1}};
  localparam logic [pDigits-1:0] AN_ONE = pDigits'(1);

  logic [SLOT_W-1:0]  slotCnt_r;
  logic [DIG_W-1:0]   digIdx_r;
  logic [31:0]        snapshot_r;
  logic               frozen_r;
  logic [6:0]         seg_r;
  logic [pDigits-1:0] an_r;

  logic [31:0]        chan_s [pChannels];
  logic [SEL_W-1:0]   chanIdx_s;
  logic [31:0]        selData_s;
  logic               loadNow_s;
  logic [31:0]        dispSnap_s;
  logic [3:0]         nib_s;
  logic               digitBlank_s;
  logic [6:0]         segNext_s;
  logic [pDigits-1:0] anNext_s;
  logic               keyRise_s;

  for (genvar g = 0; g < pChannels; g++) begin : gChan
    assign chan_s[g] = iwData[32*g +: 32];
  end

  key_debouncer #(
    .pDebounce(pDebounce)
  ) uKeyDebouncer (
    .iwClk (iwClk),
    .iwRst (iwRst),
    .iwKey (iwKey),
    .owRise(keyRise_s)
  );

  // Channel mux; the compare is one bit wider so pChannels itself is representable
  always_comb begin
    chanIdx_s = ({1'b0, iwSel} < (SEL_W + 1)'(pChannels)) ? iwSel : SEL_W'(0);
    selData_s = 32'h0000_0000;
    for (int c = 0; c < pChannels; c++) begin
      selData_s = selData_s | ({32{chanIdx_s == SEL_W'(c)}} & chan_s[c]);
    end
  end

  // Next display values from the current scan position; the load value is bypassed so a frame-start digit never shows stale data
  always_comb begin
    loadNow_s  = (slotCnt_r == SLOT_W'(0)) && (digIdx_r == DIG_W'(0)) && !frozen_r;
    dispSnap_s = loadNow_s ? selData_s : snapshot_r;
    nib_s      = dispSnap_s[{digIdx_r, 2'b00} +: 4];
`ifdef DISP_LEADING_ZERO_BLANK_EN
    begin : bTopNibble
      logic [DIG_W-1:0] topIdx;
      topIdx = DIG_W'(0);
      for (int i = 0; i < pDigits; i++) begin
        topIdx = (dispSnap_s[4*i +: 4] != 4'h0) ? DIG_W'(i) : topIdx;
      end
      digitBlank_s = (digIdx_r > topIdx);
    end
`else
    digitBlank_s = 1'b0;
`endif
    if (slotCnt_r < SLOT_W'(pGuard)) begin
      anNext_s  = AN_OFF;
      segNext_s = SEG_BLANK;
    end else begin
      anNext_s  = ~(AN_ONE << digIdx_r);
      segNext_s = digitBlank_s ? SEG_BLANK : hexToSeg(nib_s);
    end
  end

  // Slot/digit scan counters; digit index wraps to 0 at frame end
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      slotCnt_r <= '0;
      digIdx_r  <= '0;
    end else if (slotCnt_r == SLOT_W'(pRefreshDiv - 1)) begin
      slotCnt_r <= '0;
      digIdx_r  <= (digIdx_r == DIG_W'(pDigits - 1)) ? DIG_W'(0) : digIdx_r + DIG_W'(1);
    end else begin
      slotCnt_r <= slotCnt_r + SLOT_W'(1);
    end
  end

  // Frame snapshot, freeze toggle (load decision sees the pre-toggle freeze value) and registered outputs
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      snapshot_r <= 32'h0000_0000;
      frozen_r   <= 1'b0;
      seg_r      <= SEG_BLANK;
      an_r       <= AN_OFF;
    end else begin
      snapshot_r <= dispSnap_s;
      frozen_r   <= frozen_r ^ keyRise_s;
      seg_r      <= segNext_s;
      an_r       <= anNext_s;
    end
  end

  assign ownSeg   = seg_r;
  assign ownAn    = an_r;
  assign owFrozen = frozen_r;

endmodule

// File: tb/tb_multi_channel_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_display_scanner
// Directed bench: every cycle the anodes, segments and freeze flag are
// compared with values derived from the bench's own cycle count and the
// hand-chosen snapshot expected for that frame.
// -----------------------------------------------------------------------------
module tb_multi_channel_display_scanner;

  logic        clk;
  logic        rst;
  logic [31:0] ch0;
  logic [31:0] ch1;
  logic [31:0] ch2;
  logic [1:0]  sel;
  logic        key;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frozen;

  int errors = 0;
  int checks = 0;
  int phase  = 0;
  logic expFrozen;

  multi_channel_display_scanner #(
    .pDigits    (4),
    .pChannels  (3),
    .pRefreshDiv(8),
    .pGuard     (2),
    .pDebounce  (5)
  ) dut (
    .iwClk   (clk),
    .iwRst   (rst),
    .iwData  ({ch2, ch1, ch0}),
    .iwSel   (sel),
    .iwKey   (key),
    .ownSeg  (seg),
    .ownAn   (an),
    .owFrozen(frozen)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset edge; output after edge n reflects scan state n-1
  always @(posedge clk) begin
    if (rst) phase <= 0;
    else     phase <= phase + 1;
  end

  function automatic logic [6:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] segFor(input logic [15:0] v, input int d);
    logic [3:0] n;
    int top;
    top = 0;
    for (int i = 0; i < 4; i++) if (((v >> (4*i)) & 16'hF) != 16'h0) top = i;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (d > top) return 7'h7F;
`endif
    n = 4'((v >> (4*d)) & 16'hF);
    return hexSeg(n);
  endfunction

  task automatic cyc(input string tag, input logic [15:0] v);
    logic [3:0] eAn;
    logic [6:0] eSeg;
    int s;
    int d;
    @(negedge clk);
    if (phase == 0) begin
      eAn = 4'hF; eSeg = 7'h7F;
    end else begin
      s = (phase - 1) % 8;
      d = ((phase - 1) / 8) % 4;
      if (s < 2) begin
        eAn = 4'hF; eSeg = 7'h7F;
      end else begin
        eAn  = ~(4'b0001 << d);
        eSeg = segFor(v, d);
      end
    end
    checks += 3;
    assert (an === eAn) else begin
      errors++;
      $error("FAIL %s an phase=%0d: got %h expected %h", tag, phase, an, eAn);
    end
    assert (seg === eSeg) else begin
      errors++;
      $error("FAIL %s seg phase=%0d: got %h expected %h", tag, phase, seg, eSeg);
    end
    assert (frozen === expFrozen) else begin
      errors++;
      $error("FAIL %s frozen phase=%0d: got %b expected %b", tag, phase, frozen, expFrozen);
    end
  endtask

  task automatic run(input string tag, input int n, input logic [15:0] v);
    for (int k = 0; k < n; k++) cyc(tag, v);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; key = 1'b0; sel = 2'd0; expFrozen = 1'b0;
    ch0 = 32'h0000_1234; ch1 = 32'h0000_ABCD; ch2 = 32'h0000_E0F9;

    // reset state, then first frame
    cyc("reset", 16'h1234);
    cyc("reset", 16'h1234);
    rst = 1'b0;
    run("frame1", 32, 16'h1234);

    // select change mid-frame does not tear the frame
    run("frame2a", 16, 16'h1234);
    sel = 2'd1;
    run("frame2b", 16, 16'h1234);
    run("sel1", 32, 16'hABCD);

    // out-of-range select falls back to channel 0
    sel = 2'd3;
    run("sel3", 32, 16'h1234);
    sel = 2'd0;

    // short bounce: no toggle
    key = 1'b1;
    run("bounce", 3, 16'h1234);
    key = 1'b0;
    run("bounce", 13, 16'h1234);

    // long press freezes once; toggle visible 8 cycles after key rises
    key = 1'b1;
    run("press1", 7, 16'h1234);
    expFrozen = 1'b1;
    run("press1", 9, 16'h1234);
    ch0 = 32'h0000_5678;
    run("frozen", 4, 16'h1234);
    key = 1'b0;
    run("frozen", 28, 16'h1234);

    // second press unfreezes; current frame was loaded while frozen
    key = 1'b1;
    run("press2", 7, 16'h1234);
    expFrozen = 1'b0;
    run("press2", 25, 16'h1234);
    key = 1'b0;
    run("unfrozen", 8, 16'h5678);

    // freeze again so reset has something to clear
    key = 1'b1;
    run("press3", 7, 16'h5678);
    expFrozen = 1'b1;
    run("press3", 13, 16'h5678);
    key = 1'b0;
    run("press3", 4, 16'h5678);

    // reset during digit 2 slot
    run("prereset", 18, 16'h5678);
    rst = 1'b1;
    expFrozen = 1'b0;
    cyc("midreset", 16'h5678);
    rst = 1'b0;
    run("rescan", 32, 16'h5678);

    // leading-zero cases (blanked only when the feature is built in)
    ch0 = 32'h0000_0005;
    run("val5", 32, 16'h0005);
    ch0 = 32'h0000_0000;
    run("val0", 32, 16'h0000);
    ch0 = 32'hFFFF_0A05;
    run("val0A05", 32, 16'h0A05);

    // channel 2
    sel = 2'd2;
    run("sel2", 32, 16'hE0F9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
